decode_pipe: RTL and testbench

Registered instruction-decode stage for the MIPS pipeline, the successor to the combinational decoder. It sits between fetch and execute. It splits a 32-bit instruction into operand, immediate and control fields, and resolves source operands through EX/MEM forwarding. It detects load-use and RAW hazards and inserts bubbles, and presents the result in an ID/EX register with a valid/ready handshake, flush support and a stall-cycle counter.

---
 rtl/decode_pkg.sv | 37 +++
 rtl/decode_fields.sv | 37 +++
 rtl/decode_pipe.sv | 141 ++++++++++++++
 tb/tb_decode_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the registered MIPS decode stage: field positions,
// opcode constants and the ID/EX control payload.
package decode_pkg;
  localparam int INSTR_W   = 32;
  localparam int OPC_W     = 6;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b0;

  // Control half of the ID/EX register; operands and PC are carried beside it
  // because their widths follow the module parameters.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [OPC_W-1:0] aluop;
    logic [4:0]       rd;
    logic             immsel;
    logic [4:0]       shift;
  } idex_ctl_t;

  function automatic logic is_rtype(input logic [OPC_W-1:0] op);
    return op == OP_RTYPE;
  endfunction
endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction: control fields, sign-extended immediate and
// which source registers the instruction actually reads.
module decode_fields
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output idex_ctl_t          ctl,
  output logic [DATA_W-1:0]  sximm,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic               use_rs,
  output logic               use_rt
);
  logic [OPC_W-1:0] op;
  logic             rtype;

  assign op    = instr[OP_MSB:OP_LSB];
  assign rtype = is_rtype(op);
  assign rs    = instr[RS_MSB:RS_LSB];
  assign rt    = instr[RT_MSB:RT_LSB];

  always_comb begin
    ctl        = '0;
    ctl.opcode = op;
    ctl.aluop  = rtype ? instr[FUNCT_MSB:FUNCT_LSB] : op;
    ctl.rd     = rtype ? instr[RD_MSB:RD_LSB] : rt;
    ctl.immsel = !rtype;
    ctl.shift  = instr[SHAMT_MSB:SHAMT_LSB];
  end

  assign sximm  = DATA_W'($signed(instr[IMM_MSB:IMM_LSB]));
  // Every opcode reads rs; only R-type also reads rt.
  assign use_rs = 1'b1;
  assign use_rt = rtype;
endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage with EX/MEM forwarding, hazard bubbles, ID/EX
// valid/ready register, flush and stall counter. DECODE_FWD_EN enables forwarding.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int PC_W   = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic [REG_W-1:0]  rf_reada,
  output logic [REG_W-1:0]  rf_readb,
  input  logic [DATA_W-1:0] rf_douta,
  input  logic [DATA_W-1:0] rf_doutb,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_wr_rd,
  input  logic [DATA_W-1:0] ex_wr_val,
  input  logic              mem_wr_en,
  input  logic [REG_W-1:0]  mem_wr_rd,
  input  logic [DATA_W-1:0] mem_wr_val,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_aluop,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_immsel,
  output logic [DATA_W-1:0] out_vala,
  output logic [DATA_W-1:0] out_valb,
  output logic [DATA_W-1:0] out_sximm,
  output logic [4:0]        out_shift,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);
  idex_ctl_t         dec_ctl, ctl_q;
  logic [DATA_W-1:0] dec_sximm;
  logic [4:0]        rs, rt;
  logic              use_rs, use_rt;
  logic [REG_W-1:0]  src_a, src_b;
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] vala_q, valb_q, sximm_q;
  logic [PC_W-1:0]   pc_q;
  logic              hazard, adv;
  logic              unused_ok;

  decode_fields #(.DATA_W(DATA_W)) u_fields (
    .instr  (in_instr),
    .ctl    (dec_ctl),
    .sximm  (dec_sximm),
    .rs     (rs),
    .rt     (rt),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  assign src_a    = REG_W'(rs);
  assign src_b    = REG_W'(rt);
  assign rf_reada = src_a;
  assign rf_readb = src_b;

  // A writer hits when it targets a nonzero register the instruction reads.
  function automatic logic src_hit(input logic en, input logic [REG_W-1:0] d,
                                   input logic ua, input logic ub,
                                   input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return en && (d != '0) && ((ua && d == a) || (ub && d == b));
  endfunction

`ifdef DECODE_FWD_EN
  function automatic logic [DATA_W-1:0] resolve(input logic [REG_W-1:0] s,
                                                input logic [DATA_W-1:0] rfv);
    if (s == '0)                                     return '0;
    else if (ex_wr_en && !ex_is_load && ex_wr_rd == s) return ex_wr_val;
    else if (mem_wr_en && mem_wr_rd == s)            return mem_wr_val;
    else                                             return rfv;
  endfunction

  assign hazard = src_hit(ex_wr_en && ex_is_load, ex_wr_rd, use_rs, use_rt, src_a, src_b);
`else
  function automatic logic [DATA_W-1:0] resolve(input logic [REG_W-1:0] s,
                                                input logic [DATA_W-1:0] rfv);
    return (s == '0) ? '0 : rfv;
  endfunction

  // Without bypasses any in-flight writer of a used source must drain first.
  assign hazard = src_hit(ex_wr_en,  ex_wr_rd,  use_rs, use_rt, src_a, src_b) ||
                  src_hit(mem_wr_en, mem_wr_rd, use_rs, use_rt, src_a, src_b);
`endif

  assign opa       = resolve(src_a, rf_douta);
  assign opb       = resolve(src_b, rf_doutb);
  assign unused_ok = ^{ex_wr_val, mem_wr_val, ex_is_load};

  assign adv      = !out_valid || out_ready;
  assign in_ready = !rst && (flush || (adv && !hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctl_q     <= '0;
      vala_q    <= '0;
      valb_q    <= '0;
      sximm_q   <= '0;
      pc_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        if (in_valid && !hazard) begin
          ctl_q     <= dec_ctl;
          vala_q    <= opa;
          valb_q    <= opb;
          sximm_q   <= dec_sximm;
          pc_q      <= in_pc;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (in_valid && hazard && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_opcode = ctl_q.opcode;
  assign out_aluop  = ctl_q.aluop;
  assign out_rd     = REG_W'(ctl_q.rd);
  assign out_immsel = ctl_q.immsel;
  assign out_shift  = ctl_q.shift;
  assign out_vala   = vala_q;
  assign out_valb   = valb_q;
  assign out_sximm  = sximm_q;
  assign out_pc     = pc_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed test-plan cases then random traffic
// against a behavioural model of the stage.
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ex_wr_en, ex_is_load, mem_wr_en, flush;
  logic        out_valid, out_ready, out_immsel;
  logic [31:0] in_instr, rf_douta, rf_doutb, ex_wr_val, mem_wr_val;
  logic [31:0] out_vala, out_valb, out_sximm;
  logic [8:0]  in_pc, out_pc;
  logic [4:0]  rf_reada, rf_readb, ex_wr_rd, mem_wr_rd, out_rd, out_shift;
  logic [5:0]  out_opcode, out_aluop;
  logic [15:0] stall_cnt;

  decode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_reada(rf_reada), .rf_readb(rf_readb),
    .rf_douta(rf_douta), .rf_doutb(rf_doutb), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_wr_rd(ex_wr_rd), .ex_wr_val(ex_wr_val),
    .mem_wr_en(mem_wr_en), .mem_wr_rd(mem_wr_rd), .mem_wr_val(mem_wr_val),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_aluop(out_aluop), .out_rd(out_rd),
    .out_immsel(out_immsel), .out_vala(out_vala), .out_valb(out_valb),
    .out_sximm(out_sximm), .out_shift(out_shift), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opcode, aluop;
    logic [4:0]  rd, shift;
    logic        immsel;
    logic [31:0] vala, valb, sximm;
    logic [8:0]  pc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] rf[32];
  int          checks = 0;
  int          errors = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] rfv);
    if (r == 0) return 32'd0;
`ifdef DECODE_FWD_EN
    if (ex_wr_en && !ex_is_load && ex_wr_rd == r) return ex_wr_val;
    if (mem_wr_en && mem_wr_rd == r) return mem_wr_val;
`endif
    return rfv;
  endfunction

  function automatic logic uses(input logic [4:0] d, input logic [31:0] ins);
    if (d == 0) return 1'b0;
    return (d == ins[25:21]) || (ins[31:26] == 0 && d == ins[20:16]);
  endfunction

  // Reference model: evaluates the cycle's inputs just before the rising edge.
  always @(negedge clk) begin
    logic hz, adv, exp_rdy, rtype;
    exp_t e;
`ifdef DECODE_FWD_EN
    hz = ex_wr_en && ex_is_load && uses(ex_wr_rd, in_instr);
`else
    hz = (ex_wr_en && uses(ex_wr_rd, in_instr)) || (mem_wr_en && uses(mem_wr_rd, in_instr));
`endif
    adv     = !m_valid || out_ready;
    exp_rdy = !rst && (flush || (adv && !hz));
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
    if (rst) begin
      m_valid = 1'b0;
      m_cnt   = '0;
      sbq.delete();
    end else begin
      if (flush) begin
        if (sbq.size() > 0) void'(sbq.pop_front());
        m_valid = 1'b0;
      end else if (adv) begin
        if (in_valid && !hz) begin
          rtype    = (in_instr[31:26] == 6'd0);
          e.opcode = in_instr[31:26];
          e.aluop  = rtype ? in_instr[5:0] : in_instr[31:26];
          e.rd     = rtype ? in_instr[15:11] : in_instr[20:16];
          e.immsel = !rtype;
          e.shift  = in_instr[10:6];
          e.vala   = opnd(in_instr[25:21], rf_douta);
          e.valb   = opnd(in_instr[20:16], rf_doutb);
          e.sximm  = {{16{in_instr[15]}}, in_instr[15:0]};
          e.pc     = in_pc;
          sbq.push_back(e);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (in_valid && hz && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  // Monitor: compares the ID/EX register whenever execute takes it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %0h expected no output", out_pc);
      end else begin
        e = sbq.pop_front();
        chk("opcode", {26'd0, out_opcode}, {26'd0, e.opcode});
        chk("aluop",  {26'd0, out_aluop},  {26'd0, e.aluop});
        chk("rd",     {27'd0, out_rd},     {27'd0, e.rd});
        chk("immsel", {31'd0, out_immsel}, {31'd0, e.immsel});
        chk("shift",  {27'd0, out_shift},  {27'd0, e.shift});
        chk("vala",   out_vala,  e.vala);
        chk("valb",   out_valb,  e.valb);
        chk("sximm",  out_sximm, e.sximm);
        chk("pc",     {23'd0, out_pc}, {23'd0, e.pc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    in_instr = ins;
    rf_douta = rf[ins[25:21]];
    rf_doutb = rf[ins[20:16]];
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; flush = 0; out_ready = 1;
    ex_wr_en = 0; ex_is_load = 0; ex_wr_rd = 0; ex_wr_val = 0;
    mem_wr_en = 0; mem_wr_rd = 0; mem_wr_val = 0;
  endtask

  task automatic reset_checks();
    chk("rst_vala",  out_vala,  32'd0);
    chk("rst_valb",  out_valb,  32'd0);
    chk("rst_sximm", out_sximm, 32'd0);
    chk("rst_pc",    {23'd0, out_pc}, 32'd0);
    chk("rst_aluop", {26'd0, out_aluop}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd55; rf[1] = 32'd11; rf[2] = 32'd22;
    idle();
    rst = 1; in_pc = 9'd0;
    set_instr(32'd0);
    repeat (3) step();
    reset_checks();

    // add $3,$1,$2 then addi $5,$1,-4
    idle(); in_valid = 1; in_pc = 9'h010; set_instr(32'h00221820); step();
    in_pc = 9'h014; set_instr(32'h2025FFFC); step();
    // EX and MEM both write $1: EX wins; then MEM supplies $2
    in_pc = 9'h018; set_instr(32'h00221820);
    ex_wr_en = 1; ex_wr_rd = 1; ex_wr_val = 100;
    mem_wr_en = 1; mem_wr_rd = 1; mem_wr_val = 50; step();
    idle(); in_valid = 1; in_pc = 9'h01c;
    mem_wr_en = 1; mem_wr_rd = 2; mem_wr_val = 7; step();
    // load-use on $2: one bubble, then accepted once the load clears
    idle(); in_valid = 1; in_pc = 9'h020;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_rd = 2; step();
    ex_wr_en = 0; ex_is_load = 0; step();
    // backpressure for three cycles, then flush while stalled
    in_pc = 9'h024; set_instr(32'h2025FFFC); out_ready = 0;
    repeat (3) step();
    flush = 1; step();
    flush = 0; out_ready = 1; in_valid = 0; step();
    // $0 is never forwarded, even from a non-load EX write
    in_valid = 1; in_pc = 9'h028; set_instr(32'h00001820);
    ex_wr_en = 1; ex_wr_rd = 0; ex_wr_val = 99; step();
    idle(); rst = 1; step(); step();
    reset_checks();

    idle();
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      op        = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 63));
      set_instr({op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)});
      in_pc      = 9'($urandom);
      ex_wr_en   = ($urandom_range(0, 2) == 0);
      ex_is_load = ($urandom_range(0, 1) == 1);
      ex_wr_rd   = 5'($urandom_range(0, 3));
      ex_wr_val  = $urandom;
      mem_wr_en  = ($urandom_range(0, 2) == 0);
      mem_wr_rd  = 5'($urandom_range(0, 3));
      mem_wr_val = $urandom;
      flush      = ($urandom_range(0, 19) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    idle(); repeat (4) step();
    chk("drain_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
